muldiv_ctrl: RTL and testbench

//  Sequencer for RV32M MUL/DIV/REM ops issued in the EX stage alongside the ALU.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_ctrl_if.sv | 22 ++
 rtl/muldiv_ctrl_core.sv | 69 ++++++
 rtl/muldiv_ctrl.sv | 132 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and operand-signedness helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // MUL is treated as signed; its low half is identical either way.
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == MUL) || (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == MUL) || (f3 == MULH) || (f3 == DIV) || (f3 == REM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> M-extension unit handshake bundle.
interface muldiv_ctrl_if #(parameter int XLEN = 32);
  logic            StartE;
  logic [2:0]      funct3E;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            FlushE;
  logic            StallMD;
  logic            Busy;
  logic            ResultValid;
  logic [XLEN-1:0] ResultMD;

  modport master (
    output StartE, funct3E, SrcA, SrcB, FlushE,
    input  StallMD, Busy, ResultValid, ResultMD
  );

  modport slave (
    input  StartE, funct3E, SrcA, SrcB, FlushE,
    output StallMD, Busy, ResultValid, ResultMD
  );
endinterface

// File: rtl/muldiv_ctrl_core.sv
// Unsigned shift-add multiply / restoring shift-subtract divide datapath, one step per en.
// MULDIV_FAST_MUL_EN: multiplies complete on load via a combinational product.
module iter_muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic            div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            div_q;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   sh;
  logic            ge;
  logic [XLEN-1:0] sub;
  logic [XLEN-1:0] div_hi, div_lo;

  // hi:lo is the product (mul) or remainder:quotient-shifting-in-dividend (div).
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    sh      = {hi_q, lo_q[XLEN-1]};
    ge      = (sh >= {1'b0, b_q});
    sub     = sh[XLEN-1:0] - b_q;
    div_hi  = ge ? sub : sh[XLEN-1:0];
    div_lo  = {lo_q[XLEN-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      b_q   <= b;
      div_q <= div;
`ifdef MULDIV_FAST_MUL_EN
      if (!div) begin
        {hi_q, lo_q} <= (2*XLEN)'(a) * (2*XLEN)'(b);
      end else begin
        hi_q <= '0;
        lo_q <= a;
      end
`else
      hi_q <= '0;
      lo_q <= a;
`endif
    end else if (en) begin
      if (div_q) begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M MUL/DIV/REM sequencer: stalls EX until the iterative result is ready.
// MULDIV_FAST_MUL_EN: multiplies finish in one stall cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctrl_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic            sa_q, sb_q, dz_q;

  logic            start, special, fast;
  logic            sa_in, sb_in, dz_in;
  logic [XLEN-1:0] amag, bmag;
  logic            core_load, core_en, stall;
  logic [XLEN-1:0] hi, lo;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   q_fix, r_src, r_fix, res;

  assign sa_in = is_signed_a(bus.funct3E) & bus.SrcA[XLEN-1];
  assign sb_in = is_signed_b(bus.funct3E) & bus.SrcB[XLEN-1];
  assign amag  = sa_in ? -bus.SrcA : bus.SrcA;
  assign bmag  = sb_in ? -bus.SrcB : bus.SrcB;
  assign dz_in = (bus.SrcB == '0);

  // Signed overflow: most-negative / -1.
  assign special = is_div(bus.funct3E) &&
                   (dz_in || (is_signed_b(bus.funct3E) &&
                              bus.SrcA == {1'b1, {(XLEN-1){1'b0}}} &&
                              bus.SrcB == '1));

`ifdef MULDIV_FAST_MUL_EN
  assign fast = !is_div(bus.funct3E);
`else
  assign fast = 1'b0;
`endif

  // rst_n gates the combinational stall so every output is low during reset.
  assign start = bus.StartE & ~bus.FlushE & rst_n;

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          core_load = 1'b1;
          state_nx  = (special || fast) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.FlushE) begin
          state_nx = IDLE;
        end else begin
          stall   = 1'b1;
          core_en = 1'b1;
          if (cnt == CW'(XLEN-1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      f3_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (core_load) begin
        cnt  <= '0;
        f3_q <= bus.funct3E;
        sa_q <= sa_in;
        sb_q <= sb_in;
        dz_q <= is_div(bus.funct3E) & dz_in;
      end else if (core_en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  iter_muldiv_core #(.XLEN(XLEN)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (core_load),
    .en    (core_en),
    .div   (is_div(bus.funct3E)),
    .a     (amag),
    .b     (bmag),
    .hi    (hi),
    .lo    (lo)
  );

  // Special cases skip the core: lo still holds |A| and hi is zero, which already
  // yields the overflow result; divide-by-zero overrides the quotient and remainder.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sa_q ^ sb_q) ? -prod : prod;
    q_fix    = dz_q ? '1 : ((sa_q ^ sb_q) ? -lo : lo);
    r_src    = dz_q ? lo : hi;
    r_fix    = sa_q ? -r_src : r_src;
    case (f3_q)
      MUL:                 res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           res = q_fix;
      default:             res = r_fix;
    endcase
  end

  assign bus.StallMD     = stall;
  assign bus.Busy        = (state != IDLE);
  assign bus.ResultValid = (state == DONE);
  assign bus.ResultMD    = (state == DONE) ? res : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl (default build: iterative multiply).
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;

  muldiv_ctrl_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one op and hold it in EX until ResultValid; returns the valid cycle.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r,
                       input int exp_stall, output int t_valid);
    int  st;
    bit  got;
    st      = 0;
    got     = 1'b0;
    t_valid = 0;
    bus.StartE  = 1'b1;
    bus.funct3E = f3;
    bus.SrcA    = a;
    bus.SrcB    = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.ResultValid) begin
        got     = 1'b1;
        t_valid = cyc;
        check_eq({tag, "_result"}, 64'(bus.ResultMD), 64'(exp_r));
        check_eq({tag, "_stall_cycles"}, 64'(st), 64'(exp_stall));
        check_eq({tag, "_stall_in_done"}, 64'(bus.StallMD), 64'd0);
      end else if (bus.StallMD) begin
        st++;
      end
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_completed"}, 64'(got), 64'd1);
    bus.StartE = 1'b0;
  endtask

  int t1, t2, pulses;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    bus.StartE  = 1'b0;
    bus.funct3E = '0;
    bus.SrcA    = '0;
    bus.SrcB    = '0;
    bus.FlushE  = 1'b0;
    rst_n = 1'b0;
    #12;
    check_eq("rst_stall", 64'(bus.StallMD), 64'd0);
    check_eq("rst_busy", 64'(bus.Busy), 64'd0);
    check_eq("rst_valid", 64'(bus.ResultValid), 64'd0);
    check_eq("rst_result", 64'(bus.ResultMD), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("mul",    MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, t1);
    do_op("mulhu",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, t1);
    do_op("mulh",   MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33, t1);
    do_op("mulhsu", MULHSU, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF, 33, t1);
    do_op("div",    DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, t1);
    do_op("rem",    REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, t1);
    do_op("divu",   DIVU,   32'd100,        32'd7,         32'd14,        33, t1);
    do_op("remu",   REMU,   32'd100,        32'd7,         32'd2,         33, t1);
    do_op("divu0",  DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,  t1);
    do_op("remu0",  REMU,   32'd5,          32'd0,         32'd5,         1,  t1);
    do_op("rem0",   REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1,  t1);
    do_op("divov",  DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  t1);
    do_op("remov",  REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1,  t1);

    // Back-to-back: DIV then MUL with no gap.
    do_op("b2b_div", DIV, 32'd100, 32'd7,         32'd14,        33, t1);
    do_op("b2b_mul", MUL, 32'd7,   32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, t2);
    check_eq("b2b_spacing", 64'(t2 - t1), 64'd34);

    // Flush at BUSY cycle 10.
    bus.StartE  = 1'b1;
    bus.funct3E = DIVU;
    bus.SrcA    = 32'd100;
    bus.SrcB    = 32'd7;
    repeat (11) @(posedge clk);
    #1 bus.FlushE = 1'b1;
    @(negedge clk);
    check_eq("flush_stall", 64'(bus.StallMD), 64'd0);
    check_eq("flush_busy_before", 64'(bus.Busy), 64'd1);
    @(posedge clk);
    #1;
    bus.FlushE = 1'b0;
    bus.StartE = 1'b0;
    check_eq("flush_idle", 64'(bus.Busy), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ResultValid) pulses++;
    end
    check_eq("flush_no_valid", 64'(pulses), 64'd0);

    // Flush while IDLE with StartE: no start.
    @(posedge clk);
    #1;
    bus.StartE = 1'b1;
    bus.FlushE = 1'b1;
    @(negedge clk);
    check_eq("idle_flush_stall", 64'(bus.StallMD), 64'd0);
    @(posedge clk);
    #1;
    check_eq("idle_flush_busy", 64'(bus.Busy), 64'd0);
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;

    // Asynchronous reset mid-BUSY.
    @(posedge clk);
    #1;
    bus.StartE  = 1'b1;
    bus.funct3E = MUL;
    bus.SrcA    = 32'd7;
    bus.SrcB    = 32'd3;
    repeat (6) @(posedge clk);
    #3;
    check_eq("pre_rst_busy", 64'(bus.Busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_stall", 64'(bus.StallMD), 64'd0);
    check_eq("midrst_busy", 64'(bus.Busy), 64'd0);
    check_eq("midrst_valid", 64'(bus.ResultValid), 64'd0);
    check_eq("midrst_result", 64'(bus.ResultMD), 64'd0);
    bus.StartE = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("post_rst_remu", REMU, 32'd100, 32'd7, 32'd2, 33, t1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
